// File: rtl/imem_loader_if.sv
// Wishbone slave bus bundle for the instruction memory loader.
interface imem_loader_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i,
        output wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i,
        input  wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/imem_loader.sv
// Wishbone loader for the 256x8 instruction memory; holds the CPU in reset until run.
// IMEM_LOADER_READBACK_EN enables 4-cycle DATA readback from the memory.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    imem_loader_if.slave wb,
    output logic [7:0]   imem_addr,
    output logic [7:0]   imem_wdata,
    output logic         imem_we,
    input  logic [7:0]   imem_rdata,
    output logic         cpu_rst
);
    typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;

    state_t      state;
    logic [1:0]  lane;
    logic [1:0]  rsel;
    logic        wr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic        run;
    logic        autoinc;
    logic [7:0]  ptr;
    logic [7:0]  cnt;
    logic        act;
    logic        req;
    logic        go_xfer;
    logic [1:0]  nlane;
    logic [31:0] rd_mux;

    assign act   = wb.wbs_cyc_i & wb.wbs_stb_i;
    assign req   = act & (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign nlane = lane + 2'd1;

`ifdef IMEM_LOADER_READBACK_EN
    logic [23:0] rbuf;
    assign go_xfer = wb.wbs_adr_i[3:2] == 2'd2;
`else
    logic unused_rdata;
    assign unused_rdata = ^imem_rdata;
    assign go_xfer = (wb.wbs_adr_i[3:2] == 2'd2) & wb.wbs_we_i;
`endif

    logic unused_adr;
    assign unused_adr = ^wb.wbs_adr_i[1:0];

    always_comb begin
        rd_mux = '0;
        unique case (wb.wbs_adr_i[3:2])
            2'd0:    rd_mux = {30'd0, autoinc, run};
            2'd1:    rd_mux = {24'd0, ptr};
            2'd3:    rd_mux = {16'd0, cnt, 7'd0, run};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            lane         <= '0;
            rsel         <= '0;
            wr           <= 1'b0;
            sel          <= '0;
            wdat         <= '0;
            run          <= 1'b0;
            autoinc      <= 1'b0;
            ptr          <= '0;
            cnt          <= '0;
            cpu_rst      <= 1'b1;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            imem_we      <= 1'b0;
            wb.wbs_ack_o <= 1'b0;
            wb.wbs_dat_o <= '0;
`ifdef IMEM_LOADER_READBACK_EN
            rbuf         <= '0;
`endif
        end else begin
            wb.wbs_ack_o <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            // the memory commits every strobed byte, including an aborted lane
            if (imem_we)
                cnt <= cnt + 8'd1;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        rsel <= wb.wbs_adr_i[3:2];
                        wr   <= wb.wbs_we_i;
                        sel  <= wb.wbs_sel_i;
                        wdat <= wb.wbs_dat_i;
                        if (go_xfer) begin
                            state      <= XFER;
                            lane       <= 2'd0;
                            imem_addr  <= ptr;
                            imem_wdata <= wb.wbs_dat_i[7:0];
                            imem_we    <= wb.wbs_we_i
                                        & wb.wbs_sel_i[0] & ~run;
                        end else begin
                            state        <= ACK;
                            wb.wbs_ack_o <= 1'b1;
                            if (!wb.wbs_we_i)
                                wb.wbs_dat_o <= rd_mux;
                        end
                    end
                end
                XFER: begin
                    if (!act) begin
                        state <= IDLE;
                    end else begin
`ifdef IMEM_LOADER_READBACK_EN
                        if (!wr) begin
                            unique case (lane)
                                2'd0: rbuf[7:0]   <= imem_rdata;
                                2'd1: rbuf[15:8]  <= imem_rdata;
                                2'd2: rbuf[23:16] <= imem_rdata;
                                default: wb.wbs_dat_o <= {imem_rdata, rbuf};
                            endcase
                        end
`endif
                        if (lane == 2'd3) begin
                            state        <= ACK;
                            wb.wbs_ack_o <= 1'b1;
                        end else begin
                            lane       <= nlane;
                            imem_addr  <= ptr + {6'd0, nlane};
                            imem_wdata <= wdat[{nlane, 3'b000} +: 8];
                            imem_we    <= wr & sel[nlane] & ~run;
                        end
                    end
                end
                ACK: begin
                    state <= IDLE;
                    if (wr && rsel == 2'd0 && sel[0]) begin
                        run     <= wdat[0];
                        autoinc <= wdat[1];
                        cpu_rst <= ~wdat[0];
                    end
                    if (wr && rsel == 2'd1 && sel[0])
                        ptr <= wdat[7:0];
                    if (rsel == 2'd2 && autoinc)
                        ptr <= ptr + 8'd4;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: register table plus abort and reset sequences.
module tb_imem_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] imem_addr;
    logic [7:0] imem_wdata;
    logic       imem_we;
    logic [7:0] imem_rdata;
    logic       cpu_rst;
    logic [7:0] mem [256];

    int errors = 0;
    int checks = 0;
    logic rst_at_ack;
    logic ack_after;

    imem_loader_if bus();

    imem_loader dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb        (bus),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .imem_we   (imem_we),
        .imem_rdata(imem_rdata),
        .cpu_rst   (cpu_rst)
    );

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];
    always @(posedge clk)
        if (imem_we) mem[imem_addr] <= imem_wdata;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d,
                           output logic [31:0] r, output int lat);
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = w;
        bus.wbs_adr_i = a;
        bus.wbs_sel_i = s;
        bus.wbs_dat_i = d;
        lat = -1;
        r = 'x;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.wbs_ack_o) begin
                lat = i;
                r = bus.wbs_dat_o;
                rst_at_ack = cpu_rst;
                break;
            end
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        @(posedge clk);
        #1;
        ack_after = bus.wbs_ack_o;
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        chk;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam logic [31:0] B = 32'h3000_0000;
`ifdef IMEM_LOADER_READBACK_EN
    localparam logic [31:0] RB_EXP = 32'hDDCC_BBAA;
    localparam int          RB_LAT = 5;
`else
    localparam logic [31:0] RB_EXP = 32'h0;
    localparam int          RB_LAT = 1;
`endif

    vec_t vecs [16];
    logic [31:0] r;
    int lat;
    int wcount;
    logic seen;

    initial begin
        foreach (mem[i]) mem[i] = 8'h00;
        bus.wbs_cyc_i = 0;
        bus.wbs_stb_i = 0;
        bus.wbs_we_i  = 0;
        bus.wbs_sel_i = 0;
        bus.wbs_dat_i = 0;
        bus.wbs_adr_i = 0;

        vecs[0]  = '{"rd_status0", 0, B+12, 4'hF, 0, 1, 32'h0, 1};
        vecs[1]  = '{"rd_ctrl0", 0, B+0, 4'hF, 0, 1, 32'h0, 1};
        vecs[2]  = '{"rd_ptr0", 0, B+4, 4'hF, 0, 1, 32'h0, 1};
        vecs[3]  = '{"wr_ptr10", 1, B+4, 4'hF, 32'h10, 0, 0, 1};
        vecs[4]  = '{"wr_ctrl2", 1, B+0, 4'hF, 32'h2, 0, 0, 1};
        vecs[5]  = '{"wr_data1", 1, B+8, 4'hF, 32'hDDCCBBAA, 0, 0, 5};
        vecs[6]  = '{"rd_ptr14", 0, B+4, 4'hF, 0, 1, 32'h14, 1};
        vecs[7]  = '{"rd_status4", 0, B+12, 4'hF, 0, 1, 32'h0400, 1};
        vecs[8]  = '{"wr_ptrfe", 1, B+4, 4'hF, 32'hFE, 0, 0, 1};
        vecs[9]  = '{"wr_data2", 1, B+8, 4'h5, 32'h44332211, 0, 0, 5};
        vecs[10] = '{"rd_ptr02", 0, B+4, 4'hF, 0, 1, 32'h02, 1};
        vecs[11] = '{"rd_status6", 0, B+12, 4'hF, 0, 1, 32'h0600, 1};
        vecs[12] = '{"wr_ptr10b", 1, B+4, 4'hF, 32'h10, 0, 0, 1};
        vecs[13] = '{"rd_data", 0, B+8, 4'hF, 0, 1, RB_EXP, RB_LAT};
        vecs[14] = '{"rd_ptr_ai", 0, B+4, 4'hF, 0, 1, 32'h14, 1};
        vecs[15] = '{"rd_ctrl2", 0, B+0, 4'hF, 0, 1, 32'h2, 1};

        repeat (2) @(posedge clk);
        #1;
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_ack", bus.wbs_ack_o, 0);
        check("rst_dat", bus.wbs_dat_o, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, r, lat);
            check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            check({vecs[i].name, "_ackpulse"}, ack_after, 0);
            if (vecs[i].chk)
                check({vecs[i].name, "_rd"}, r, vecs[i].exp);
        end

        check("mem10", mem[8'h10], 8'hAA);
        check("mem11", mem[8'h11], 8'hBB);
        check("mem12", mem[8'h12], 8'hCC);
        check("mem13", mem[8'h13], 8'hDD);
        check("memfe", mem[8'hFE], 8'h11);
        check("memff", mem[8'hFF], 8'h00);
        check("mem00", mem[8'h00], 8'h33);
        check("mem01", mem[8'h01], 8'h00);
        check("miss_base", 0, 0 + 0) ;
        checks--;

        // non-matching base is never acked
        wb_xfer(0, 32'h3000_1000, 4'hF, 0, r, lat);
        check("nomatch_lat", lat, -1);

        // run=1 blocks writes but still acks and releases the CPU
        wb_xfer(1, B+0, 4'hF, 32'h1, r, lat);
        check("run_cpu_at_ack", rst_at_ack, 1);
        check("run_cpu_after", cpu_rst, 0);
        wb_xfer(1, B+8, 4'hF, 32'h55667788, r, lat);
        check("run_wr_lat", lat, 5);
        check("run_mem14", mem[8'h14], 8'h00);
        wb_xfer(0, B+12, 4'hF, 0, r, lat);
        check("run_status", r, 32'h0601);

        // abort a write after lane 1
        wb_xfer(1, B+0, 4'hF, 32'h2, r, lat);
        check("stop_cpu_rst", cpu_rst, 1);
        wb_xfer(1, B+4, 4'hF, 32'h20, r, lat);
        @(negedge clk);
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 1;
        bus.wbs_adr_i = B+8; bus.wbs_sel_i = 4'hF;
        bus.wbs_dat_i = 32'h0D0C0B0A;
        @(posedge clk); #1;
        check("lane0_addr", imem_addr, 8'h20);
        check("lane0_we", imem_we, 1);
        @(posedge clk); #1;
        check("lane1_addr", imem_addr, 8'h21);
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o) seen = 1;
        end
        check("abort_noack", seen, 0);
        check("abort_we", imem_we, 0);
        check("abort_m20", mem[8'h20], 8'h0A);
        check("abort_m21", mem[8'h21], 8'h0B);
        check("abort_m22", mem[8'h22], 8'h00);
        wb_xfer(0, B+4, 4'hF, 0, r, lat);
        check("abort_ptr", r, 32'h20);
        wb_xfer(0, B+12, 4'hF, 0, r, lat);
        check("abort_status", r, 32'h0800);

        // reset in the middle of a transfer
        wb_xfer(1, B+0, 4'hF, 32'h1, r, lat);
        @(negedge clk);
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 1;
        bus.wbs_adr_i = B+8; bus.wbs_sel_i = 4'hF;
        bus.wbs_dat_i = 32'hFFEEDDCC;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_addr", imem_addr, 8'h21);
        check("mid_cpu_rst", cpu_rst, 0);
        rst = 1'b1;
        #1;
        check("mr_ack", bus.wbs_ack_o, 0);
        check("mr_dat", bus.wbs_dat_o, 0);
        check("mr_we", imem_we, 0);
        check("mr_addr", imem_addr, 0);
        check("mr_wdata", imem_wdata, 0);
        check("mr_cpu_rst", cpu_rst, 1);
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
        @(negedge clk);
        rst = 1'b0;
        wb_xfer(0, B+12, 4'hF, 0, r, lat);
        check("mr_status", r, 32'h0);
        check("mr_status_lat", lat, 1);
        wb_xfer(0, B+4, 4'hF, 0, r, lat);
        check("mr_ptr", r, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        wcount = 0;
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Wishbone slave that fills the jacaranda-8 256×8 instruction memory from the Caravel management core and gates the CPU out of reset once the program is loaded. It sits directly upstream of the instruction memory and CPU inside `computer`. It drives the instruction memory's write/read-back port and the CPU reset. It answers the Caravel user-project Wishbone bus (`wbs_*`), which the core does not otherwise use.

## Interface
Parameters:
- `BASE_ADDR`, default `32'h3000_0000`: register block base; only `wbs_adr_i[31:4]` is compared.

Ports:
- `wb_clk_i` in 1: sole clock.
- `wb_rst_i` in 1: reset; asynchronous, active-high.
- `wbs_stb_i` in 1: Wishbone strobe.
- `wbs_cyc_i` in 1: Wishbone cycle.
- `wbs_we_i` in 1: write enable.
- `wbs_sel_i` in 4: byte lane select.
- `wbs_dat_i` in 32: write data.
- `wbs_adr_i` in 32: byte address.
- `wbs_ack_o` out 1: acknowledge, single-cycle pulse.
- `wbs_dat_o` out 32: read data, valid while `wbs_ack_o` is high.
- `imem_addr` out 8: instruction memory byte address.
- `imem_wdata` out 8: instruction memory write data.
- `imem_we` out 1: instruction memory write strobe, sampled on the rising edge of `wb_clk_i`.
- `imem_rdata` in 8: instruction memory combinational read data for `imem_addr`.
- `cpu_rst` out 1: CPU reset, active-high. It is the inverse of CTRL.run.

## Operation
- Decode: a request is `wbs_cyc_i & wbs_stb_i` with `wbs_adr_i[31:4] == BASE_ADDR[31:4]`. Non-matching requests are ignored and never acked. The register is selected by `wbs_adr_i[3:2]`.
- 0x0 CTRL, R/W, reset 0:
  - bit0 `run`.
  - bit1 `autoinc`.
  - Other bits read 0.
- 0x4 PTR, R/W, reset 0: bits[7:0] hold the byte pointer.
- 0x8 DATA: window onto imem bytes `PTR..PTR+3`.
  - Lane k maps to `wbs_dat_i/wbs_dat_o[8k+7:8k]`.
  - Byte address is `(PTR+k) mod 256`.
- 0xC STATUS, RO:
  - bit0 `run`.
  - bits[15:8] hold the count of imem bytes written since reset, mod 256.
- CTRL, PTR and STATUS writes honour `wbs_sel_i` per byte lane.
- FSM states: IDLE, XFER, ACK.
  - IDLE → ACK: request to CTRL, PTR or STATUS.
  - IDLE → XFER: request to DATA. The lane counter is cleared to 0.
  - XFER: one lane per cycle, lanes 0..3. After lane 3 → ACK.
  - ACK: `wbs_ack_o`=1 for exactly one cycle, then → IDLE.
- DATA write, in XFER lane k:
  - `imem_addr` = PTR+k.
  - `imem_wdata` = lane k data.
  - `imem_we` = `wbs_sel_i[k] & ~run`.
- Writes while `run`=1 drive no `imem_we`, are still acked, and do not increment the byte count.
- DATA read, in XFER lane k: `imem_addr` = PTR+k, and `imem_rdata` is registered into `wbs_dat_o` byte k.
- Autoincrement: on the ACK of a DATA access with `autoinc`=1, PTR += 4 mod 256. This applies to reads and writes, and regardless of `run`.
- Abort: if `wbs_cyc_i` or `wbs_stb_i` drops in XFER:
  - → IDLE next cycle, with no ack and no autoincrement.
  - Bytes already written stay written.
- Outside XFER: `imem_addr` = 0 and `imem_we` = 0.

## Timing
- Reset values:
  - `wbs_ack_o`=0.
  - `wbs_dat_o`=0.
  - `imem_we`=0.
  - `imem_addr`=0.
  - `imem_wdata`=0.
  - `cpu_rst`=1.
  - FSM in IDLE; CTRL, PTR and byte count all 0.
- Reset asserted mid-transfer aborts it immediately: no ack, and `cpu_rst` goes to 1.
- Register access: request sampled at edge N, ack high during cycle N+1.
  - Write data takes effect at the edge ending the ack cycle.
  - Read data is registered when entering ACK.
- DATA access: request sampled at edge N, lanes 0..3 during cycles N+1..N+4, ack during cycle N+5.
- `cpu_rst` is registered. It deasserts one cycle after the ack of a CTRL write setting `run`=1.
- Back-to-back requests: a new request is sampled only in IDLE. The minimum spacing is ack cycle + 1.
- `wbs_dat_o` holds its last value outside ack.

## Configuration
- `IMEM_LOADER_READBACK_EN`:
  - Defined: DATA reads perform the 4-cycle XFER readback described above.
  - Undefined: DATA reads take the register path (ack at N+1) and return 0; `imem_rdata` is unused; DATA writes are unchanged.

## Test plan
- Reset release → `cpu_rst`=1, CTRL=0, PTR=0. Read STATUS → 0x0000_0000, ack exactly 1 cycle after request.
- PTR←0x10, CTRL←0x2, DATA←0xDDCCBBAA with sel=0xF → `imem_we` pulses at addresses 0x10..0x13 with data AA,BB,CC,DD; ack at N+5; PTR reads 0x14; STATUS[15:8]=4.
- PTR←0xFE, DATA←0x44332211 with sel=0x5, autoinc on → writes only 0xFE←11 and 0x00←33; PTR wraps to 0x02.
- CTRL←0x1, then DATA write → no `imem_we`, ack still returned; `cpu_rst` falls 1 cycle after the CTRL ack.
- Readback (macro defined): after the write at 0x10, PTR←0x10, read DATA → 0xDDCCBBAA. Macro undefined → 0x0 at N+1.
- Drop `wbs_cyc_i` after lane 1 of a DATA write → only 2 bytes written, no ack, PTR unchanged. Assert `wb_rst_i` mid-XFER → all outputs at reset values.
